// File: rtl/prbs_ber_monitor.sv
// PRBS bit-error-rate monitor: self-seeding LFSR checker with lock/loss-of-lock FSM and saturating counters.
// Optional relock event counter enabled by defining PRBS_BER_MONITOR_RELOCK_CNT_EN.

module prbs_lane_cell #(
  parameter int ORDER = 31,
  parameter int TAP   = 28,
  parameter int LW    = 5
) (
  input  logic             seed_en,
  input  logic [ORDER-1:0] h_in,
  input  logic [LW-1:0]    ld_in,
  input  logic             d,
  output logic [ORDER-1:0] h_out,
  output logic [LW-1:0]    ld_out,
  output logic             err
);
  logic pred, load;
  assign pred   = h_in[ORDER-1] ^ h_in[TAP-1];
  assign load   = seed_en && (ld_in < LW'(ORDER));
  // While seeding, history takes received bits; otherwise it follows its own prediction.
  assign h_out  = {h_in[ORDER-2:0], load ? d : pred};
  assign ld_out = load ? ld_in + LW'(1) : ld_in;
  assign err    = !load && (d ^ pred);
endmodule

module prbs_ber_monitor #(
  parameter int LANES          = 1,
  parameter int PRBS_ORDER     = 31,
  parameter int COUNT_WIDTH    = 32,
  parameter int LOCK_COUNT     = 64,
  parameter int LOSS_WINDOW    = 256,
  parameter int LOSS_THRESHOLD = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       data_in,
  input  logic                   data_in_valid,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] total_bits,
  output logic [COUNT_WIDTH-1:0] total_bit_errors,
  output logic                   locked,
  output logic                   saturated
`ifdef PRBS_BER_MONITOR_RELOCK_CNT_EN
  ,
  output logic [15:0]            relock_count
`endif
);
  localparam int TAP = (PRBS_ORDER == 7)  ? 6  :
                       (PRBS_ORDER == 15) ? 14 :
                       (PRBS_ORDER == 23) ? 18 : 28;
  localparam int LW  = $clog2(PRBS_ORDER + 1);
  localparam int PW  = $clog2(LANES + 1);
  localparam int RW  = $clog2(LOCK_COUNT + 1);
  localparam int WW  = $clog2(LOSS_WINDOW + 1);
  localparam int EW  = $clog2(LOSS_THRESHOLD + LANES + 1);
  localparam int CW1 = COUNT_WIDTH + 1;

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t                   state;
  logic [PRBS_ORDER-1:0]    lfsr;
  logic [LW-1:0]            load_cnt;
  logic [RW-1:0]            run_cnt;
  logic [WW-1:0]            win_words;
  logic [EW-1:0]            win_errs;

  logic [LANES:0][PRBS_ORDER-1:0] h_chain;
  logic [LANES:0][LW-1:0]         ld_chain;
  logic [LANES-1:0]               err_bit;
  logic [PW-1:0]                  nerr;
  logic                           mis, loss;
  logic [EW-1:0]                  win_err_nxt;
  logic [COUNT_WIDTH:0]           bits_sum, errs_sum;
  logic [COUNT_WIDTH-1:0]         bits_nxt, errs_nxt;

  assign h_chain[0]  = lfsr;
  assign ld_chain[0] = load_cnt;

  // Bit 0 is earliest in time, so the chain walks lanes from 0 upward.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      prbs_lane_cell #(.ORDER(PRBS_ORDER), .TAP(TAP), .LW(LW)) u_cell (
        .seed_en (state == SEED),
        .h_in    (h_chain[gi]),
        .ld_in   (ld_chain[gi]),
        .d       (data_in[gi]),
        .h_out   (h_chain[gi+1]),
        .ld_out  (ld_chain[gi+1]),
        .err     (err_bit[gi])
      );
    end
  endgenerate

  always_comb begin
    nerr = '0;
    for (int i = 0; i < LANES; i++) nerr = nerr + PW'(err_bit[i]);
  end

  assign mis         = (nerr != '0);
  assign win_err_nxt = win_errs + EW'(nerr);
  assign loss        = data_in_valid && (state == LOCKED) && (win_err_nxt > EW'(LOSS_THRESHOLD));
  assign bits_sum    = {1'b0, total_bits} + CW1'(LANES);
  assign errs_sum    = {1'b0, total_bit_errors} + CW1'(nerr);
  assign bits_nxt    = bits_sum[COUNT_WIDTH] ? '1 : bits_sum[COUNT_WIDTH-1:0];
  assign errs_nxt    = errs_sum[COUNT_WIDTH] ? '1 : errs_sum[COUNT_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      lfsr      <= '0;
      load_cnt  <= '0;
      run_cnt   <= '0;
      win_words <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
    end else if (data_in_valid) begin
      lfsr <= h_chain[LANES];
      case (state)
        SEED: begin
          if (ld_chain[LANES] == LW'(PRBS_ORDER)) begin
            // Excess bits of the final seed word already failed: reseed from scratch.
            if (mis) load_cnt <= '0;
            else begin
              load_cnt <= ld_chain[LANES];
              run_cnt  <= '0;
              state    <= VERIFY;
            end
          end else begin
            load_cnt <= ld_chain[LANES];
          end
        end
        VERIFY: begin
          if (mis) begin
            state    <= SEED;
            load_cnt <= '0;
            run_cnt  <= '0;
          end else if (run_cnt == RW'(LOCK_COUNT - 1)) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            run_cnt   <= '0;
            win_words <= '0;
            win_errs  <= '0;
          end else begin
            run_cnt <= run_cnt + RW'(1);
          end
        end
        LOCKED: begin
          if (loss) begin
            state     <= SEED;
            locked    <= 1'b0;
            load_cnt  <= '0;
            win_words <= '0;
            win_errs  <= '0;
          end else if (win_words == WW'(LOSS_WINDOW - 1)) begin
            win_words <= '0;
            win_errs  <= '0;
          end else begin
            win_words <= win_words + WW'(1);
            win_errs  <= win_err_nxt;
          end
        end
        default: state <= SEED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_bits       <= '0;
      total_bit_errors <= '0;
      saturated        <= 1'b0;
    end else if (clear) begin
      total_bits       <= '0;
      total_bit_errors <= '0;
      saturated        <= 1'b0;
    end else if (data_in_valid && (state == LOCKED)) begin
      total_bits       <= bits_nxt;
      total_bit_errors <= errs_nxt;
      saturated        <= saturated | (&bits_nxt) | (&errs_nxt);
    end
  end

`ifdef PRBS_BER_MONITOR_RELOCK_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  relock_count <= '0;
    else if (clear)                           relock_count <= '0;
    else if (loss && (relock_count != 16'hFFFF)) relock_count <= relock_count + 16'd1;
  end
`endif
endmodule
